dsp48a1_rr_scheduler: RTL

- Shares one DSP48A1 slice between NREQ requesters; each requester submits A/B operands plus an OPMODE through a valid/ready handshake.
- A round-robin arbiter issues at most one operation per cycle into the slice.
- A LAT-deep tag/valid shadow pipeline tracks in-flight operations, so each slice P output is returned with its originating requester tag.
- The block also drives the slice's common clock enable, so the slice is idle-gated when nothing is in flight.

---
 rtl/dsp_sched_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/dsp48a1_rr_scheduler.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dsp_sched_pkg.sv
// Shared types and constants for the DSP48A1 round-robin scheduler.
package dsp_sched_pkg;

    localparam int LAT_DEFAULT = 4;

    // Widest tag needed for the supported requester range (up to 8).
    localparam int TAG_MAX_W = 3;

    localparam logic [7:0] OPM_MUL        = 8'h01;
    localparam logic [7:0] OPM_MAC        = 8'h09;
    localparam logic [7:0] OPM_PREADD_MUL = 8'h11;

    // One shadow pipeline stage: tracks whether the slice stage holds a real op and whose it is.
    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
    } shadow_stage_t;

    // Tag width for n requesters; never narrower than one bit.
    function automatic int tag_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins, searching upward with wrap.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int TW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [TW-1:0]   ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [TW-1:0]   idx
);

    logic          found;
    logic [TW-1:0] kk;

    // Rotating priority search starting at the pointer.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        kk    = '0;
        for (int i = 0; i < NREQ; i++) begin
            kk = TW'((int'(ptr) + i) % NREQ);
            if (en && req[kk] && !found) begin
                found     = 1'b1;
                grant[kk] = 1'b1;
                idx       = kk;
            end
        end
    end

endmodule

// File: rtl/dsp48a1_rr_scheduler.sv
// Round-robin scheduler sharing one DSP48A1 slice between NREQ requesters.
// A shadow tag/valid pipeline mirrors the slice so each P output leaves with its requester tag.
// Optional result back-pressure: define DSP_SCHED_STALL_EN to add the res_ready port.
module dsp48a1_rr_scheduler
    import dsp_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = 18,
    parameter int BW   = 18,
    parameter int PW   = 48,
    parameter int LAT  = LAT_DEFAULT,
    parameter int TW   = tag_width(NREQ)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*AW-1:0]       req_a,
    input  logic [NREQ*BW-1:0]       req_b,
    input  logic [NREQ*8-1:0]        req_opmode,
    output logic [AW-1:0]            dsp_a,
    output logic [BW-1:0]            dsp_b,
    output logic [7:0]               dsp_opmode,
    output logic                     dsp_ce,
    input  logic [PW-1:0]            dsp_p,
    output logic                     res_valid,
    output logic [TW-1:0]            res_tag,
    output logic [PW-1:0]            res_p,
`ifdef DSP_SCHED_STALL_EN
    input  logic                     res_ready,
`endif
    output logic [$clog2(LAT+1)-1:0] inflight
);

    localparam int IW = $clog2(LAT+1);

    logic            stall;
    logic            adv;
    logic            accept;
    logic            arb_en;
    logic [TW-1:0]   ptr_q, ptr_d;
    logic [TW-1:0]   gidx;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   inflight_q, inflight_d;
    shadow_stage_t   stage_q [LAT];
    shadow_stage_t   stage_in;
    shadow_stage_t   last;
    logic            unused_tag;

    assign last = stage_q[LAT-1];

`ifdef DSP_SCHED_STALL_EN
    assign stall = last.valid & ~res_ready;
`else
    assign stall = 1'b0;
`endif

    // Nothing is accepted while reset is held, so ready stays low during reset.
    assign adv    = (|req_valid | (inflight_q != '0)) & ~stall & ~RST;
    assign dsp_ce = adv;
    assign arb_en = ~stall;

    rr_arbiter #(
        .NREQ (NREQ),
        .TW   (TW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .en    (arb_en),
        .grant (grant),
        .idx   (gidx)
    );

    assign req_ready = grant & {NREQ{adv}};
    assign accept    = |(req_valid & req_ready);

    // Operand mux from the granted requester; zeros form a bubble when nobody is granted.
    always_comb begin
        dsp_a      = '0;
        dsp_b      = '0;
        dsp_opmode = '0;
        if (|grant) begin
            dsp_a      = req_a[int'(gidx)*AW +: AW];
            dsp_b      = req_b[int'(gidx)*BW +: BW];
            dsp_opmode = req_opmode[int'(gidx)*8 +: 8];
        end
    end

    // Next pointer: one past the accepted requester, with wrap.
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (gidx == TW'(NREQ-1)) ? '0 : gidx + TW'(1);
        end
    end

    // Next in-flight count: entries enter on accept and leave from the last stage.
    always_comb begin
        inflight_d = inflight_q;
        if (adv) begin
            inflight_d = inflight_q + IW'(accept) - IW'(last.valid);
        end
    end

    // Entry into stage 0 of the shadow pipeline.
    always_comb begin
        stage_in       = '0;
        stage_in.valid = accept;
        stage_in.tag   = TAG_MAX_W'(gidx);
    end

    // Pointer and in-flight counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr_q      <= '0;
            inflight_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            inflight_q <= inflight_d;
        end
    end

    // Shadow pipeline moves in lockstep with the slice CE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < LAT; k++) begin
                stage_q[k] <= '0;
            end
        end else if (adv) begin
            stage_q[0] <= stage_in;
            for (int k = 1; k < LAT; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign res_valid  = last.valid;
    assign res_tag    = last.tag[TW-1:0];
    assign res_p      = dsp_p;
    assign inflight   = inflight_q;
    assign unused_tag = ^last.tag;

endmodule
